tree_settle_checker: RTL and testbench

Drives a single stimulus edge into the root of an inverter fan-out tree and monitors the four leaf outputs coming back from it. It measures the cycles until all leaves reach their expected level, counts glitches during a hold window and reports pass/fail. It sits on the bench/characterisation side of the tree, opposite the fan-out: one output drives the root, four inputs receive the leaves.

---
 rtl/tree_settle_checker.sv | 171 +++++++++++++++++
 tb/tb_tree_settle_checker.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tree_settle_checker.sv
//==============================================================================
// Module      : tree_settle_checker
// Description : Launches one edge into an inverter fan-out tree root and
//               measures leaf settle time and hold-window glitches.
//               Optional leaf synchroniser: TREE_CHK_SYNC_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tree_settle_checker #(
    parameter int SETTLE_MAX = 15,
    parameter int HOLD_CYC   = 4,
    parameter int CNT_W      = 8,
    parameter int INVERT     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             level,
    output logic             din_o,
    input  logic [3:0]       leaf_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] settle_cycles,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int                c_HW         = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [c_HW-1:0]   c_HOLD_LAST  = c_HW'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]  c_SETTLE_MAX = CNT_W'(SETTLE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_din;
    logic [3:0]       r_exp;
    logic [3:0]       r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [c_HW-1:0]  r_hcnt;
    logic [CNT_W-1:0] r_settle;
    logic [CNT_W-1:0] r_glitch;
    logic             r_pass;
    logic             r_timeout;
    logic [3:0]       w_leaf_s;

`ifdef TREE_CHK_SYNC_EN
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= leaf_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_leaf_s = r_sync2;
`else
    assign w_leaf_s = leaf_i;
`endif

    logic             w_match;
    logic             w_limit;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [3:0]       w_dep;
    logic [2:0]       w_add;
    logic [CNT_W:0]   w_gsum;
    logic [CNT_W-1:0] w_gsat;

    assign w_match   = (w_leaf_s == r_exp);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_limit   = (w_cnt_inc == c_SETTLE_MAX);

    // A glitch is a fresh departure: mismatch now, match on the previous sample.
    assign w_dep  = (w_leaf_s ^ r_exp) & ~(r_prev ^ r_exp);
    assign w_add  = {2'b00, w_dep[0]} + {2'b00, w_dep[1]} + {2'b00, w_dep[2]} + {2'b00, w_dep[3]};
    assign w_gsum = {1'b0, r_glitch} + (CNT_W+1)'(w_add);
    assign w_gsat = w_gsum[CNT_W] ? {CNT_W{1'b1}} : w_gsum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_WAIT;
            S_WAIT: begin
                if (w_match)      w_next = S_HOLD;
                else if (w_limit) w_next = S_DONE;
            end
            S_HOLD: if (r_hcnt == c_HOLD_LAST) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_din     <= 1'b0;
            r_exp     <= 4'b0000;
            r_prev    <= 4'b0000;
            r_cnt     <= '0;
            r_hcnt    <= '0;
            r_settle  <= '0;
            r_glitch  <= '0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_prev <= w_leaf_s;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_din     <= level;
                        r_exp     <= {4{level ^ (INVERT != 0)}};
                        r_cnt     <= '0;
                        r_hcnt    <= '0;
                        r_settle  <= '0;
                        r_glitch  <= '0;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (w_match) begin
                        r_settle <= w_cnt_inc;
                    end else if (w_limit) begin
                        r_timeout <= 1'b1;
                    end
                end
                S_HOLD: begin
                    r_glitch <= w_gsat;
                    r_hcnt   <= r_hcnt + 1'b1;
                    // Verdict is registered on DONE entry so it is valid alongside done.
                    if (r_hcnt == c_HOLD_LAST) begin
                        r_pass <= (w_gsat == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign din_o         = r_din;
    assign busy          = (r_state == S_WAIT) || (r_state == S_HOLD);
    assign done          = (r_state == S_DONE);
    assign pass          = r_pass;
    assign timeout       = r_timeout;
    assign settle_cycles = r_settle;
    assign glitch_cnt    = r_glitch;

endmodule

`default_nettype wire

// File: tb/tb_tree_settle_checker.sv
//==============================================================================
// Module      : tb_tree_settle_checker
// Description : Scoreboard bench for tree_settle_checker; follows
//               TREE_CHK_SYNC_EN for leaf latency.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tree_settle_checker;

    localparam int SETTLE_MAX = 15;
    localparam int HOLD_CYC   = 4;
    localparam int CNT_W      = 8;
`ifdef TREE_CHK_SYNC_EN
    localparam int c_LAT = 2;
`else
    localparam int c_LAT = 0;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic             level;
    logic             din_o;
    logic [3:0]       leaf_i;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [CNT_W-1:0] settle_cycles;
    logic [CNT_W-1:0] glitch_cnt;

    tree_settle_checker #(
        .SETTLE_MAX(SETTLE_MAX),
        .HOLD_CYC  (HOLD_CYC),
        .CNT_W     (CNT_W),
        .INVERT    (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .level        (level),
        .din_o        (din_o),
        .leaf_i       (leaf_i),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout),
        .settle_cycles(settle_cycles),
        .glitch_cnt   (glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       pass;
        logic       to;
        logic [7:0] settle;
        logic [7:0] glitch;
        int         done_e;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [3:0] seq_q[$];
    int         e0 = 0;
    int         chk_cnt = 0;
    int         err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected result model: settle index counts WAIT samples starting at E1.
    function automatic exp_t mk(input int s, input int g, input bit to);
        exp_t r;
        r.settle = 8'(s);
        r.glitch = 8'(g);
        r.to     = to;
        r.pass   = !to && (g == 0);
        r.done_e = to ? SETTLE_MAX + 1 : s + HOLD_CYC + 1;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("pass",          32'(pass),          32'(mon_e.pass));
                check("timeout",       32'(timeout),       32'(mon_e.to));
                check("settle_cycles", 32'(settle_cycles), 32'(mon_e.settle));
                check("glitch_cnt",    32'(glitch_cnt),    32'(mon_e.glitch));
                check("done_edge",     32'(cyc - e0 + 1),  32'(mon_e.done_e));
                check("busy_at_done",  32'(busy),          32'd0);
            end
        end
    end

    task automatic run_case(input logic lvl, input logic [3:0] pre, input exp_t e);
        int n;
        leaf_i = pre;
        repeat (3) @(negedge clk);
        start = 1'b1;
        level = lvl;
        sb_q.push_back(e);
        @(negedge clk);
        e0    = cyc;
        start = 1'b0;
        check("din_o_after_start", 32'(din_o), 32'(lvl));
        check("busy_after_start",  32'(busy),  32'd1);
        foreach (seq_q[j]) begin
            leaf_i = seq_q[j];
            @(negedge clk);
        end
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check("done_wait_expired", 32'd0, 32'd1);
            sb_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        level  = 1'b0;
        leaf_i = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_din_o",   32'(din_o),         32'd0);
        check("rst_busy",    32'(busy),          32'd0);
        check("rst_done",    32'(done),          32'd0);
        check("rst_pass",    32'(pass),          32'd0);
        check("rst_timeout", 32'(timeout),       32'd0);
        check("rst_settle",  32'(settle_cycles), 32'd0);
        check("rst_glitch",  32'(glitch_cnt),    32'd0);
        rst = 1'b0;

        // Immediate settle, leaves low for level=1
        seq_q = '{4'b0000};
        run_case(1'b1, 4'b1111, mk(1 + c_LAT, 0, 1'b0));

        // Staggered rise: dout1 seen at E2 ... dout4 at E5
        seq_q = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
        run_case(1'b0, 4'b0000, mk(5 + c_LAT, 0, 1'b0));

        // Stuck leaves give a timeout
        seq_q = '{4'b0101};
        run_case(1'b1, 4'b0101, mk(0, 0, 1'b1));

        // Single dout2 dip, then dout2+dout3 together
        seq_q = '{4'b1111, 4'b1101, 4'b1111, 4'b1001, 4'b1111};
        run_case(1'b0, 4'b0101, mk(1 + c_LAT, 3, 1'b0));

`ifndef TREE_CHK_SYNC_EN
        // Same level as current drive: leaves already match
        seq_q = '{4'b1111};
        run_case(1'b0, 4'b1111, mk(1, 0, 1'b0));
`endif

        // Start ignored mid-WAIT, then reset mid-HOLD
        leaf_i = 4'b1111;
        @(negedge clk);
        start = 1'b1;
        level = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("din_o_second_launch", 32'(din_o), 32'd1);
        @(negedge clk);
        start = 1'b1;
        level = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("din_o_ignored_start", 32'(din_o), 32'd1);
        check("busy_ignored_start",  32'(busy),  32'd1);
        leaf_i = 4'b0000;
        repeat (2 + c_LAT) @(negedge clk);
        check("busy_in_hold", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_din_o",   32'(din_o),         32'd0);
        check("mid_rst_busy",    32'(busy),          32'd0);
        check("mid_rst_pass",    32'(pass),          32'd0);
        check("mid_rst_settle",  32'(settle_cycles), 32'd0);
        check("mid_rst_timeout", 32'(timeout),       32'd0);
        check("mid_rst_glitch",  32'(glitch_cnt),    32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_after_rst_busy", 32'(busy), 32'd0);

        // Start accepted after reset
        seq_q = '{4'b0000};
        run_case(1'b1, 4'b1111, mk(1 + c_LAT, 0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
